msx_flash_responder: RTL
========================

// Module: msx_flash_responder
// PURPOSE
//  Responder side of the slot flash request interface (flash_req/flash_addr/flash_din -> flash_ready/flash_done).
//  Executes flash-cart byte PROGRAM (read-modify-write, new = old & din) and SECTOR ERASE (fill 0xFF) on the
//  shared RAM/SDRAM backing store through a req/ack memory port. Sits between msx_slots and the memory arbiter.
// PARAMETERS
//  ADDR_W       27  width of flash_addr / mem_addr (byte address in backing store)
//  SECTOR_BITS  16  log2 of erase sector size in bytes (64 KB); erase base = addr with low SECTOR_BITS cleared
// PORTS
//  clk          in   1       system clock; single clock domain
//  reset        in   1       asynchronous, active-high reset
//  flash_req    in   1       command strobe; sampled only while flash_ready=1
//  flash_erase  in   1       command type with flash_req: 0=program byte, 1=erase sector
//  flash_addr   in   ADDR_W  target byte address
//  flash_din    in   8       program data (ignored for erase)
//  flash_ready  out  1       responder idle, accepts flash_req this cycle
//  flash_done   out  1       one-cycle pulse: command completed
//  erase_busy   out  1       high for the whole duration of a sector erase (debug)
//  mem_req      out  1       memory access request; held until mem_ack
//  mem_we       out  1       1=write, 0=read; valid while mem_req=1
//  mem_addr     out  ADDR_W  memory address; valid while mem_req=1
//  mem_din      out  8       write data to memory; valid while mem_req=1 and mem_we=1
//  mem_dout     in   8       read data; valid in the cycle mem_ack=1 of a read
//  mem_ack      in   1       one-cycle acknowledge of the current mem_req
// BEHAVIOUR
//  Reset (async): state=IDLE; flash_ready=1, flash_done=0, erase_busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_din=0.
//  States: IDLE, RD_REQ, WR_REQ, ER_REQ, DONE. All outputs registered.
//  IDLE: flash_ready=1. On flash_req: latch addr/din/erase; ready drops next cycle.
//    erase=0 -> RD_REQ; erase=1 -> ER_REQ with counter=0, base=addr & ~(2^SECTOR_BITS-1).
//  RD_REQ: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack: merged=mem_dout & din.
//    merged==mem_dout (no bit clears) -> DONE, write skipped; else -> WR_REQ with mem_din=merged.
//  WR_REQ: mem_req=1, mem_we=1, mem_addr=latched addr, mem_din=merged. On mem_ack -> DONE.
//  ER_REQ: erase_busy=1, mem_req=1, mem_we=1, mem_din=8'hFF, mem_addr=base|counter (SECTOR_BITS-bit counter).
//    On mem_ack: counter all-ones -> DONE; else counter+1, stay (mem_req stays high, addr advances next cycle).
//  DONE: flash_done=1 for exactly one cycle, erase_busy=0, mem_req=0; next cycle IDLE (ready=1).
//  Handshake rules:
//    - mem_req never drops before mem_ack; mem_addr/we/din stable while mem_req=1 and not acked.
//    - mem_ack outside RD_REQ/WR_REQ/ER_REQ is ignored.
//    - flash_req while ready=0 is ignored (not queued); the requester must hold or re-issue.
//    - mem_ack and a new flash_req in the same cycle: only the ack is processed.
//  Latency (ack in cycle after req):
//    program with write: 1 accept + 2 (read) + 2 (write) + done pulse.
//    no-change program: write omitted.
//    erase: 2^SECTOR_BITS writes, one per ack.
//  Width: counter exactly SECTOR_BITS wide; address = base OR counter, never carries into upper bits.
//  Reset mid-operation: abort immediately, no flash_done, mem_req=0; partial erase is not resumed.
// TESTING (SECTOR_BITS overridden to 4 where noted; memory model acks 1 cycle after req)
//  1. Reset: outputs at reset values; assert reset during WR_REQ -> mem_req=0, flash_done never pulses, flash_ready=1.
//  2. Program addr=0x123 din=0x0F over mem 0xF5 -> read 0x123, write 0x05 to 0x123, one flash_done pulse, ready=1.
//  3. Program din=0xFF over mem 0x3C -> only read issued, no write cycle (mem_we never 1), flash_done pulses.
//  4. SECTOR_BITS=4, erase addr=0x1237 -> 16 writes of 0xFF to 0x1230..0x123F in order, erase_busy high
//     throughout, one done pulse.
//  5. Ack stall: withhold mem_ack 10 cycles in RD_REQ -> mem_req/addr/we stable; second flash_req during busy ignored.
//  6. Random program/erase mix vs reference model (flash AND semantics) -> memory image matches; done count == accepted cmds.

Source files
------------

// File: rtl/msx_flash_responder.sv
// rtl/msx_flash_responder.sv - flash-cart program/erase responder over a req/ack backing-store port
module msx_flash_responder #(
    parameter int ADDR_W      = 27,
    parameter int SECTOR_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flash_req,
    input  logic              flash_erase,
    input  logic [ADDR_W-1:0] flash_addr,
    input  logic [7:0]        flash_din,
    output logic              flash_ready,
    output logic              flash_done,
    output logic              erase_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_ER   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             din_q, din_d;
    logic [SECTOR_BITS-1:0] cnt_q, cnt_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [7:0]             mem_din_q, mem_din_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [7:0]             merged;
    logic [SECTOR_BITS-1:0] cnt_inc;
    logic [ADDR_W-1:0]      sector_base;

    assign merged      = mem_dout & din_q;
    assign cnt_inc     = cnt_q + 1'b1;
    assign sector_base = {flash_addr[ADDR_W-1:SECTOR_BITS], {SECTOR_BITS{1'b0}}};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (flash_req) begin
                    din_d     = flash_din;
                    ready_d   = 1'b0;
                    mem_req_d = 1'b1;
                    if (flash_erase) begin
                        // addr_q holds the sector base during erase; the counter supplies the low bits
                        addr_d     = sector_base;
                        cnt_d      = '0;
                        mem_we_d   = 1'b1;
                        mem_din_d  = 8'hFF;
                        mem_addr_d = sector_base;
                        busy_d     = 1'b1;
                        state_d    = S_ER;
                    end else begin
                        addr_d     = flash_addr;
                        mem_we_d   = 1'b0;
                        mem_addr_d = flash_addr;
                        state_d    = S_RD;
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    if (merged == mem_dout) begin
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        mem_we_d  = 1'b1;
                        mem_din_d = merged;
                        state_d   = S_WR;
                    end
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_ER: begin
                if (mem_ack) begin
                    if (&cnt_q) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_addr_d = {addr_q[ADDR_W-1:SECTOR_BITS], cnt_inc};
                    end
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign flash_ready = ready_q;
    assign flash_done  = done_q;
    assign erase_busy  = busy_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;

endmodule
